// File: rtl/shared_debounce_scheduler.sv
// Debounces NUM_BTN active-low buttons with one shared settle timer, granted round-robin
// to buttons with a pending press edge; emits one registered pulse per confirmed press.
module shared_debounce_scheduler #(
  parameter int NUM_BTN    = 4,
  parameter int WAIT_COUNT = 480000,
  parameter int CNT_W      = 20,
  parameter int ID_W       = 2
) (
  input  logic               clk,
  input  logic               rst_btn,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic               busy,
  output logic [ID_W-1:0]    active_id,
  output logic [7:0]         press_count,
  output logic [7:0]         reject_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(WAIT_COUNT - 1);

  state_t             state, state_next;
  logic [NUM_BTN-1:0] sync_p0, sync_p1;
  logic [NUM_BTN-1:0] pressed_s, pressed_d, press_edge;
  logic [NUM_BTN-1:0] pending, set_mask, clr_mask, hit_vec;
  logic [CNT_W-1:0]   timer;
  logic [ID_W-1:0]    rr_ptr, grant_id, rr_next;
  logic               grant_vld, sample_hit, sample_miss;

  // Stage p0/p1: two-flop synchronizer; p2: one-cycle delay for edge detection
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sync_p0   <= '1;
      sync_p1   <= '1;
      pressed_d <= '0;
    end else begin
      sync_p0   <= btn_n;
      sync_p1   <= sync_p0;
      pressed_d <= pressed_s;
    end
  end

  assign pressed_s  = ~sync_p1;
  assign press_edge = pressed_s & ~pressed_d;

  // Scan downwards so the lowest offset from rr_ptr is the one left standing
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % NUM_BTN]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'((int'(rr_ptr) + k) % NUM_BTN);
      end
    end
  end

  assign rr_next = ID_W'((int'(grant_id) + 1) % NUM_BTN);

  // New edges on the button under test are bounce; the sample clears its own request
  always_comb begin
    set_mask = press_edge;
    clr_mask = '0;
    hit_vec  = '0;
    if (busy) set_mask[active_id] = 1'b0;
    if (state == ST_SAMPLE) clr_mask[active_id] = 1'b1;
    hit_vec[active_id] = sample_hit;
  end

  assign sample_hit  = (state == ST_SAMPLE) &&  pressed_s[active_id];
  assign sample_miss = (state == ST_SAMPLE) && !pressed_s[active_id];

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE:   state_next = grant_vld ? ST_WAIT : ST_IDLE;
      ST_WAIT:   state_next = (timer == TIMER_LAST) ? ST_SAMPLE : ST_WAIT;
      ST_SAMPLE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_WAIT) || (state == ST_SAMPLE);
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      pending      <= '0;
      timer        <= '0;
      rr_ptr       <= '0;
      active_id    <= '0;
      press_pulse  <= '0;
      press_count  <= '0;
      reject_count <= '0;
    end else begin
      pending     <= (pending | set_mask) & ~clr_mask;
      press_pulse <= hit_vec;
      if (sample_hit)  press_count  <= press_count + 8'd1;
      if (sample_miss) reject_count <= reject_count + 8'd1;
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            active_id <= grant_id;
            rr_ptr    <= rr_next;
            timer     <= '0;
          end
        end
        ST_WAIT: timer <= timer + 1'b1;
        default: timer <= '0;
      endcase
    end
  end

endmodule

// File: doc/shared_debounce_scheduler.md
Name: shared_debounce_scheduler

Overview:
- Debounces NUM_BTN active-low pushbuttons using one shared wait timer instead of one timer per button.
- Each button's press edge raises a pending request. A round-robin scheduler grants the timer to one button at a time, waits WAIT_COUNT clocks, then resamples that button.
- Sits between the raw board buttons and counter/LED logic. Outputs one clean single-cycle pulse per accepted press.

Parameters:
- NUM_BTN, 4, number of buttons sharing the timer (2..8).
- WAIT_COUNT, 480000, settle time in clocks (40 ms at 12 MHz); must be >= 2.
- CNT_W, 20, timer width; must satisfy 2^CNT_W >= WAIT_COUNT.
- ID_W, 2, width of the button index; equals clog2(NUM_BTN).

Ports:
- clk  input  1  system clock (12 MHz).
- rst_btn  input  1  asynchronous, active-low reset; asserts immediately, all flops clear.
- btn_n  input  NUM_BTN  raw active-low buttons; asynchronous to clk.
- press_pulse  output  NUM_BTN  one-cycle high pulse on bit i per accepted press of button i.
- busy  output  1  high while the timer is granted (WAIT or SAMPLE state).
- active_id  output  ID_W  index of the granted button; holds the last grant when idle.
- press_count  output  8  total accepted presses, all buttons; wraps 255->0.
- reject_count  output  8  grants whose resample found the button released; wraps 255->0.

Behaviour:
- Reset values: press_pulse=0, busy=0, active_id=0, press_count=0, reject_count=0; state=IDLE; timer=0; pending=0; rr_ptr=0.
- Reset values also apply to the sync flops, which reset to 1 (not pressed), and to pressed_d=0.
- Input path:
  - Per bit, two-flop synchronizer on btn_n; pressed_s = ~sync2.
  - pressed_d = pressed_s delayed one cycle.
  - edge[i] = pressed_s[i] & ~pressed_d[i].
- pending[i] set on edge[i], with one exception: edges of the currently granted button are ignored while busy (treated as bounce).
- pending[i] is cleared only in SAMPLE, for i = active_id. If set and clear land on the same bit in the same cycle, clear wins; that case can only arise as the ignored-edge exception above.
- FSM states: IDLE, WAIT, SAMPLE.
- IDLE:
  - If pending is nonzero, grant the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_BTN.
  - On grant: active_id <= that index, rr_ptr <= index+1 (mod NUM_BTN), timer <= 0, state <= WAIT.
  - If pending is zero, stay in IDLE.
- WAIT:
  - timer increments by 1 each cycle.
  - When timer == WAIT_COUNT-1, state <= SAMPLE.
  - WAIT therefore lasts exactly WAIT_COUNT cycles.
- SAMPLE (one cycle):
  - If pressed_s[active_id]=1: press_pulse[active_id] <= 1 for the next cycle and press_count increments.
  - Otherwise reject_count increments.
  - In both cases pending[active_id] clears, timer <= 0, state <= IDLE.
- Timing:
  - press_pulse is registered and never has more than one bit high.
  - Latency from the btn_n falling edge (no contention) to press_pulse: 2 sync + 1 edge/pending + 1 grant + WAIT_COUNT + 1 sample = WAIT_COUNT+5 cycles, ±1 for async sampling.
- Held button: a button held past the sample produces no further pulses until it is released and pressed again (new edge).
- Simultaneous edges on several buttons: all set pending and are served in round-robin order, each with a full WAIT_COUNT window. Maximum wait before service is (NUM_BTN-1)*(WAIT_COUNT+2) cycles.
- The same button is never granted twice in a row while another button is pending.
- Illegal state encodings return to IDLE with busy=0.
- Reset mid-WAIT: immediate return to reset values; pending requests and counters are lost; no pulse is emitted.

Test Plan (bench uses WAIT_COUNT=8, NUM_BTN=4):
- Clean press: btn_n[1] goes low and is held 30 cycles. Required: exactly one press_pulse[1] at 13±1 cycles after the falling edge; press_count=1; busy high for 9 cycles.
- Bounce: btn_n[0] toggles low/high every 2 cycles for 6 cycles, then is held low. Required: one press_pulse[0] only; reject_count=0; press_count=1.
- Glitch: btn_n[2] is low for 3 cycles, then high. Required: no pulse; reject_count=1.
- Contention: btn_n[0..3] all fall in the same cycle and are held. Required: pulses in order 0,1,2,3, spaced 10 cycles apart; press_count=4.
- Fairness: rr_ptr=2 after serving button 1, then buttons 0 and 3 are pending. Required: button 3 is served before button 0.
- Reset and wrap:
  - rst_btn pulsed low mid-WAIT: all outputs 0 asynchronously; no pulse after release.
  - 256 accepted presses: press_count wraps to 0.
